// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes, instruction-type codes and itype classification helpers
// for the execute-datapath sequencer.
package stage_sequencer_pkg;

    // Width of the shared memory-wait counter; covers MEM_TIMEOUT up to 255.
    localparam int CTR_W = 8;

    // Stage codes seen by the ALU/decode blocks; code 6 is deliberately unused.
    typedef enum logic [2:0] {
        STG_FETCH   = 3'd0,
        STG_DECODE  = 3'd1,
        STG_OPERAND = 3'd2,
        STG_EXECUTE = 3'd3,
        STG_MEM     = 3'd4,
        STG_WB      = 3'd5,
        STG_TRAP    = 3'd7
    } stage_e;

    // Decoded instruction-type codes shared with the decoder.
    localparam logic [4:0] ITY_RTYPE  = 5'd0;
    localparam logic [4:0] ITY_ITYPE  = 5'd1;
    localparam logic [4:0] ITY_STYPE  = 5'd2;
    localparam logic [4:0] ITY_BTYPE  = 5'd3;
    localparam logic [4:0] ITY_UTYPE  = 5'd4;
    localparam logic [4:0] ITY_LTYPE  = 5'd5;
    localparam logic [4:0] ITY_JRTYPE = 5'd6;

    // True for any of the seven instruction types the core understands.
    function automatic logic itype_known(input logic [4:0] itype);
        logic known;
        case (itype)
            ITY_RTYPE, ITY_ITYPE, ITY_STYPE, ITY_BTYPE,
            ITY_UTYPE, ITY_LTYPE, ITY_JRTYPE: known = 1'b1;
            default:                          known = 1'b0;
        endcase
        return known;
    endfunction

    // Loads and stores are the only types that visit the MEM stage.
    function automatic logic itype_is_mem(input logic [4:0] itype);
        logic is_mem;
        case (itype)
            ITY_LTYPE, ITY_STYPE: is_mem = 1'b1;
            default:              is_mem = 1'b0;
        endcase
        return is_mem;
    endfunction

    // Stores and branches produce no register-file result.
    function automatic logic itype_writes_rf(input logic [4:0] itype);
        logic writes;
        case (itype)
            ITY_RTYPE, ITY_ITYPE, ITY_UTYPE,
            ITY_LTYPE, ITY_JRTYPE: writes = 1'b1;
            default:               writes = 1'b0;
        endcase
        return writes;
    endfunction

endpackage

// File: rtl/stage_sequencer_mem_timeout_ctr.sv
// Wait-cycle counter shared by the FETCH and MEM stages (never active together).
// expire_o flags the last permitted wait cycle before a timeout fault.
module stage_sequencer_mem_timeout_ctr
    import stage_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CTR_W-1:0] count_r;

    // Count wait cycles; clear has priority so every stage entry starts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CTR_W{1'b0}};
        end else if (clr_i) begin
            count_r <= {CTR_W{1'b0}};
        end else if (en_i) begin
            count_r <= count_r + {{(CTR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire_o = (count_r == CTR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> OPERAND -> EXECUTE -> [MEM] -> WB.
// Every output is a flop loaded from the next-state decode, so the ALU strobes
// are glitch-free and outputs change only on clk edges (or async reset).
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STAGE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic [4:0]         itype_i,
    output logic               imem_req_o,
    input  logic               imem_ack_i,
    output logic               ir_we_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    input  logic               dmem_ack_i,
    output logic [STAGE_W-1:0] stage_o,
    output logic               readin_a_o,
    output logic               readin_b_o,
    output logic               readin_pass_o,
    output logic               rf_we_o,
    output logic               pc_we_o,
    output logic               fault_o
);

    stage_e state_r;
    stage_e next_state_s;

    logic ctr_clr_s;
    logic ctr_en_s;
    logic ctr_expire_s;

    logic imem_req_r, ir_we_r, dmem_req_r, dmem_we_r;
    logic readin_r, rf_we_r, pc_we_r, fault_r;

    logic imem_req_nxt_s, ir_we_nxt_s, dmem_req_nxt_s, dmem_we_nxt_s;
    logic readin_nxt_s, rf_we_nxt_s, pc_we_nxt_s, fault_nxt_s;

    stage_sequencer_mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (ctr_clr_s),
        .en_i     (ctr_en_s),
        .expire_o (ctr_expire_s)
    );

    // Next-state selection; an ack on the expiry cycle still completes the access.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            STG_FETCH: begin
                if (imem_ack_i) begin
                    next_state_s = STG_DECODE;
                end else if (ctr_expire_s) begin
                    next_state_s = STG_TRAP;
                end else begin
                    next_state_s = STG_FETCH;
                end
            end
            STG_DECODE: begin
                if (itype_known(itype_i)) begin
                    next_state_s = STG_OPERAND;
                end else begin
                    next_state_s = STG_TRAP;
                end
            end
            STG_OPERAND: next_state_s = STG_EXECUTE;
            STG_EXECUTE: begin
                if (itype_is_mem(itype_i)) begin
                    next_state_s = STG_MEM;
                end else begin
                    next_state_s = STG_WB;
                end
            end
            STG_MEM: begin
                if (dmem_ack_i) begin
                    next_state_s = STG_WB;
                end else if (ctr_expire_s) begin
                    next_state_s = STG_TRAP;
                end else begin
                    next_state_s = STG_MEM;
                end
            end
            STG_WB:   next_state_s = STG_FETCH;
            STG_TRAP: next_state_s = STG_TRAP;
            default:  next_state_s = STG_TRAP;
        endcase
    end

    // Counter control and next output values, decoded from the upcoming state.
    always_comb begin
        ctr_en_s       = 1'b0;
        ctr_clr_s      = 1'b0;
        imem_req_nxt_s = 1'b0;
        ir_we_nxt_s    = 1'b0;
        dmem_req_nxt_s = 1'b0;
        dmem_we_nxt_s  = 1'b0;
        readin_nxt_s   = 1'b0;
        rf_we_nxt_s    = 1'b0;
        pc_we_nxt_s    = 1'b0;
        fault_nxt_s    = fault_r;
        if (!stall_i) begin
            ctr_clr_s = (next_state_s != state_r);
            ctr_en_s  = (state_r == STG_FETCH) || (state_r == STG_MEM);
        end else begin
            ctr_clr_s = 1'b0;
            ctr_en_s  = 1'b0;
        end
        case (next_state_s)
            STG_FETCH:   imem_req_nxt_s = 1'b1;
            STG_DECODE:  ir_we_nxt_s    = (state_r == STG_FETCH);
            STG_OPERAND: readin_nxt_s   = 1'b1;
            STG_EXECUTE: readin_nxt_s   = 1'b0;
            STG_MEM: begin
                dmem_req_nxt_s = 1'b1;
                dmem_we_nxt_s  = (itype_i == ITY_STYPE);
            end
            STG_WB: begin
                pc_we_nxt_s = 1'b1;
                rf_we_nxt_s = itype_writes_rf(itype_i);
            end
            STG_TRAP: fault_nxt_s = 1'b1;
            default:  fault_nxt_s = 1'b1;
        endcase
    end

    // State and output registers; a stall freezes everything in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= STG_FETCH;
            imem_req_r <= 1'b1;
            ir_we_r    <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            readin_r   <= 1'b0;
            rf_we_r    <= 1'b0;
            pc_we_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else if (!stall_i) begin
            state_r    <= next_state_s;
            imem_req_r <= imem_req_nxt_s;
            ir_we_r    <= ir_we_nxt_s;
            dmem_req_r <= dmem_req_nxt_s;
            dmem_we_r  <= dmem_we_nxt_s;
            readin_r   <= readin_nxt_s;
            rf_we_r    <= rf_we_nxt_s;
            pc_we_r    <= pc_we_nxt_s;
            fault_r    <= fault_nxt_s;
        end else begin
            state_r    <= state_r;
            imem_req_r <= imem_req_r;
            ir_we_r    <= ir_we_r;
            dmem_req_r <= dmem_req_r;
            dmem_we_r  <= dmem_we_r;
            readin_r   <= readin_r;
            rf_we_r    <= rf_we_r;
            pc_we_r    <= pc_we_r;
            fault_r    <= fault_r;
        end
    end

    assign stage_o       = STAGE_W'(state_r);
    assign imem_req_o    = imem_req_r;
    assign ir_we_o       = ir_we_r;
    assign dmem_req_o    = dmem_req_r;
    assign dmem_we_o     = dmem_we_r;
    assign readin_a_o    = readin_r;
    assign readin_b_o    = readin_r;
    assign readin_pass_o = readin_r;
    assign rf_we_o       = rf_we_r;
    assign pc_we_o       = pc_we_r;
    assign fault_o       = fault_r;

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle control FSM that sequences the execute datapath through fetch, decode, operand-load, execute, memory and writeback.
- Drives the ALU's stage_i code and its readin_a/readin_b/readin_pass latch strobes.
- Handshakes with the instruction and data memory ports.
- Issues the register-file and PC write enables.
- Sits between the core top level and the decode/ALU/memory blocks.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for imem/dmem ack before fault; range 2..255
STAGE_W, 3, width of the stage code

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
stall_i  input  1  external freeze; holds the state and all counters
itype_i  input  5  decoded instruction type (`RTYPE/`ITYPE/`STYPE/`BTYPE/`UTYPE/`LTYPE/`JRTYPE); valid from DECODE onward
imem_req_o  output  1  instruction fetch request
imem_ack_i  input  1  fetch data valid
ir_we_o  output  1  one-cycle pulse: latch instruction register
dmem_req_o  output  1  data access request
dmem_we_o  output  1  data access is a store
dmem_ack_i  input  1  data access complete
stage_o  output  STAGE_W  current stage code to ALU/decode
readin_a_o  output  1  ALU operand-A latch strobe
readin_b_o  output  1  ALU operand-B latch strobe
readin_pass_o  output  1  ALU pass latch strobe
rf_we_o  output  1  register-file write pulse
pc_we_o  output  1  PC update pulse
fault_o  output  1  sticky: memory timeout or unknown itype

Behaviour:
- States and stage codes: FETCH=0, DECODE=1, OPERAND=2, EXECUTE=3, MEM=4, WB=5, TRAP=7. Code 6 is unused.
- stage_o equals the state code.
- Reset (reset=0, async): state=FETCH, timeout counter=0, fault_o=0.
- Reset values of all other outputs: 0, except imem_req_o.
  - imem_req_o is decoded from FETCH, so it is 1 immediately after reset release.
- Reset mid-operation aborts any pending memory access; no handshake completion is needed.
- All strobe and pulse outputs (readin_*, ir_we_o, rf_we_o, pc_we_o) come directly from flops, with no combinational decode. The ALU uses the readin strobes as edge triggers, so they must be glitch-free.
- stall_i=1: state, counter and all outputs are frozen. One-cycle pulses stay high for the whole stall; this is acceptable because the consumers are edge/level-idempotent.
- FETCH:
  - imem_req_o=1.
  - On a cycle with imem_ack_i=1: ir_we_o pulses the next cycle, then -> DECODE.
  - Otherwise the counter increments; when the counter reaches MEM_TIMEOUT-1 without ack -> TRAP.
- DECODE: one cycle -> OPERAND.
  - If itype_i is not one of the seven known codes -> TRAP.
- OPERAND: readin_a_o, readin_b_o and readin_pass_o are all 1 for exactly this one cycle (rising edge at state entry) -> EXECUTE.
- EXECUTE: one cycle; the ALU computes on the closing clk edge.
  - LTYPE or STYPE -> MEM.
  - All other types -> WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 iff STYPE.
  - On dmem_ack_i=1 -> WB.
  - Timeout rule identical to FETCH -> TRAP.
  - The counter is cleared on every state entry.
- WB: one cycle.
  - pc_we_o=1.
  - rf_we_o=1 for R/I/U/L/JR types; rf_we_o=0 for S/B types.
  - Then -> FETCH.
- TRAP: fault_o=1, no requests, no pulses. Held until reset.
- Ack arriving in the same cycle as the timeout threshold: ack wins.
- Ack outside FETCH/MEM is ignored.
- Instruction latency without wait states: R/I/U/B/JR = 5 cycles; L/S = 6 cycles.

Decomposition:
- Stage codes (FETCH..TRAP) go into the shared opcode/itype include as `STG_* defines.
- itype codes are reused from itype.v.
- Sub-module mem_timeout_ctr: clear, enable, count, expire at MEM_TIMEOUT-1. Instanced once and shared by FETCH and MEM, since the two are mutually exclusive.

Test Plan:
- Reset low 3 cycles, release; imem_ack_i=1 always, itype=`RTYPE -> stage_o sequence 0,1,2,3,5,0.
  - readin_* high only in cycle with stage 2.
  - rf_we_o and pc_we_o high only in stage 5.
- `LTYPE with dmem_ack_i asserted 2 cycles after MEM entry -> stage sequence 0,1,2,3,4,4,4,5.
  - dmem_we_o=0 throughout.
  - rf_we_o=1 in WB.
- `STYPE then `BTYPE -> dmem_we_o=1 in MEM for the store.
  - rf_we_o=0 in both WBs; pc_we_o=1 in both.
- MEM_TIMEOUT=4, imem_ack_i held 0 -> TRAP entered 4 cycles after FETCH entry; fault_o=1 sticky; imem_req_o=0.
  - Same run with ack on cycle 4 -> DECODE, no fault.
- stall_i=1 for 3 cycles during OPERAND -> stage_o stays 2 and readin_* stay 1.
  - EXECUTE follows on the cycle after stall_i falls.
- reset driven low mid-MEM (asynchronous, between clk edges) -> immediately stage_o=0, dmem_req_o=0, fault_o=0.
- itype_i=5'h1F in DECODE -> TRAP next cycle; no readin_* strobe seen.
